// File: rtl/pipe_wb_latch.sv
// pipe_wb_latch: multi-lane MEM->WB latch with flush, same-bundle WAW collapse and $zero suppression.
// Define PIPE_WB_PERF_EN to build the saturating retire/bubble counters; otherwise perf_* read 0.
module pipe_wb_latch #(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES-1:0]            mem_valid,
  input  logic [LANES-1:0]            mem_we,
  input  logic [LANES*ADDR_WIDTH-1:0] mem_waddr,
  input  logic [LANES*DATA_WIDTH-1:0] mem_wdata,
  input  logic                        mem_hilo_we,
  input  logic [2*DATA_WIDTH-1:0]     mem_hilo,
  input  logic                        stall_mem,
  input  logic                        stall_wb,
  input  logic                        flush,
  output logic [LANES-1:0]            wb_valid,
  output logic [LANES-1:0]            wb_we,
  output logic [LANES*ADDR_WIDTH-1:0] wb_waddr,
  output logic [LANES*DATA_WIDTH-1:0] wb_wdata,
  output logic                        wb_hilo_we,
  output logic [2*DATA_WIDTH-1:0]     wb_hilo,
  output logic [CNT_WIDTH-1:0]        perf_retired,
  output logic [CNT_WIDTH-1:0]        perf_bubbles
);

  logic [LANES-1:0]            valid_r;
  logic [LANES-1:0]            we_r;
  logic [LANES*ADDR_WIDTH-1:0] waddr_r;
  logic [LANES*DATA_WIDTH-1:0] wdata_r;
  logic                        hilo_we_r;
  logic [2*DATA_WIDTH-1:0]     hilo_r;

  logic [LANES-1:0] base_we_s;
  logic [LANES-1:0] keep_we_s;
  logic             clear_s;
  logic             load_s;

  assign clear_s = flush | (stall_mem & ~stall_wb);
  assign load_s  = ~stall_mem;

  // Qualify each lane's write, then drop any write shadowed by a younger lane to the same register.
  always_comb begin
    base_we_s = {LANES{1'b0}};
    keep_we_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      base_we_s[i] = mem_we[i] & mem_valid[i] &
                     (mem_waddr[i*ADDR_WIDTH +: ADDR_WIDTH] != {ADDR_WIDTH{1'b0}});
    end
    for (int i = 0; i < LANES; i++) begin
      keep_we_s[i] = base_we_s[i];
      for (int j = i + 1; j < LANES; j++) begin
        keep_we_s[i] = keep_we_s[i] &
                       ~(base_we_s[j] &
                         (mem_waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == mem_waddr[i*ADDR_WIDTH +: ADDR_WIDTH]));
      end
    end
  end

  // Bundle register: reset/flush/bubble clear, load when MEM advances, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      valid_r   <= {LANES{1'b0}};
      we_r      <= {LANES{1'b0}};
      waddr_r   <= {(LANES*ADDR_WIDTH){1'b0}};
      wdata_r   <= {(LANES*DATA_WIDTH){1'b0}};
      hilo_we_r <= 1'b0;
      hilo_r    <= {(2*DATA_WIDTH){1'b0}};
    end else if (load_s) begin
      valid_r   <= mem_valid;
      we_r      <= keep_we_s;
      waddr_r   <= mem_waddr;
      wdata_r   <= mem_wdata;
      hilo_we_r <= mem_hilo_we & (|mem_valid);
      hilo_r    <= mem_hilo;
    end else begin
      valid_r   <= valid_r;
      we_r      <= we_r;
      waddr_r   <= waddr_r;
      wdata_r   <= wdata_r;
      hilo_we_r <= hilo_we_r;
      hilo_r    <= hilo_r;
    end
  end

  assign wb_valid   = valid_r;
  assign wb_we      = we_r;
  assign wb_waddr   = waddr_r;
  assign wb_wdata   = wdata_r;
  assign wb_hilo_we = hilo_we_r;
  assign wb_hilo    = hilo_r;

`ifdef PIPE_WB_PERF_EN
  // Sum width leaves headroom above the counter so the overflow compare is exact.
  localparam int SUM_W = CNT_WIDTH + 4;

  logic [CNT_WIDTH-1:0] retired_r;
  logic [CNT_WIDTH-1:0] bubbles_r;

  function automatic logic [SUM_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [SUM_W-1:0] cnt;
    cnt = {SUM_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + {{(SUM_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [SUM_W-1:0]     b);
    logic [SUM_W-1:0] sum;
    sum = {4'b0000, a} + b;
    if (sum > {4'b0000, {CNT_WIDTH{1'b1}}}) begin
      return {CNT_WIDTH{1'b1}};
    end else begin
      return sum[CNT_WIDTH-1:0];
    end
  endfunction

  // Counters follow the bundle priority but hold across a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_r <= {CNT_WIDTH{1'b0}};
      bubbles_r <= {CNT_WIDTH{1'b0}};
    end else if (flush) begin
      retired_r <= retired_r;
      bubbles_r <= bubbles_r;
    end else if (stall_mem && !stall_wb) begin
      retired_r <= retired_r;
      bubbles_r <= sat_add(bubbles_r, {{(SUM_W-1){1'b0}}, 1'b1});
    end else if (load_s) begin
      retired_r <= sat_add(retired_r, popcount(mem_valid));
      bubbles_r <= bubbles_r;
    end else begin
      retired_r <= retired_r;
      bubbles_r <= bubbles_r;
    end
  end

  assign perf_retired = retired_r;
  assign perf_bubbles = bubbles_r;
`else
  assign perf_retired = {CNT_WIDTH{1'b0}};
  assign perf_bubbles = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_wb_latch.sv
// Scoreboard bench for pipe_wb_latch: directed plan items plus randomized traffic against a reference model.
module tb_pipe_wb_latch;
  localparam int L    = 2;
  localparam int D    = 32;
  localparam int A    = 5;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [L-1:0]   mem_valid = '0;
  logic [L-1:0]   mem_we    = '0;
  logic [L*A-1:0] mem_waddr = '0;
  logic [L*D-1:0] mem_wdata = '0;
  logic           mem_hilo_we = 1'b0;
  logic [2*D-1:0] mem_hilo  = '0;
  logic stall_mem = 1'b0;
  logic stall_wb  = 1'b0;
  logic flush     = 1'b0;
  logic [L-1:0]   wb_valid;
  logic [L-1:0]   wb_we;
  logic [L*A-1:0] wb_waddr;
  logic [L*D-1:0] wb_wdata;
  logic           wb_hilo_we;
  logic [2*D-1:0] wb_hilo;
  logic [CW-1:0]  perf_retired;
  logic [CW-1:0]  perf_bubbles;

  always #5 clk = ~clk;

  pipe_wb_latch #(.LANES(L), .DATA_WIDTH(D), .ADDR_WIDTH(A), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_hilo_we(mem_hilo_we), .mem_hilo(mem_hilo),
    .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_hilo_we(wb_hilo_we), .wb_hilo(wb_hilo),
    .perf_retired(perf_retired), .perf_bubbles(perf_bubbles)
  );

  typedef struct {
    logic [L-1:0]   valid;
    logic [L-1:0]   we;
    logic [L*A-1:0] waddr;
    logic [L*D-1:0] wdata;
    logic           hilo_we;
    logic [2*D-1:0] hilo;
    int             retired;
    int             bubbles;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int checks = 0;
  int failures = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic int addr_of(input int i);
    return int'(mem_waddr[i*A +: A]);
  endfunction

  function automatic exp_t cleared(input exp_t s);
    exp_t n;
    n = s;
    n.valid = '0; n.we = '0; n.waddr = '0; n.wdata = '0; n.hilo_we = 1'b0; n.hilo = '0;
    return n;
  endfunction

  // Apply the latch rules to the inputs currently driven, queue the expected result, advance a cycle.
  task automatic step();
    exp_t n;
    int last [32];
    n = m;
    if (rst) begin
      n = cleared(m);
      n.retired = 0;
      n.bubbles = 0;
    end else if (flush) begin
      n = cleared(m);
    end else if (stall_mem && !stall_wb) begin
      n = cleared(m);
      n.bubbles = sat(m.bubbles + 1);
    end else if (!stall_mem) begin
      for (int a = 0; a < 32; a++) last[a] = -1;
      for (int i = 0; i < L; i++)
        if (mem_valid[i] && mem_we[i] && addr_of(i) != 0) last[addr_of(i)] = i;
      for (int i = 0; i < L; i++) n.we[i] = (last[addr_of(i)] == i);
      n.valid   = mem_valid;
      n.waddr   = mem_waddr;
      n.wdata   = mem_wdata;
      n.hilo_we = mem_hilo_we && (mem_valid != '0);
      n.hilo    = mem_hilo;
      n.retired = sat(m.retired + $countones(mem_valid));
    end
    m = n;
    q.push_back(n);
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic v, input logic we, input int addr, input logic [D-1:0] data);
    mem_valid[i] = v;
    mem_we[i]    = we;
    mem_waddr[i*A +: A] = A'(addr);
    mem_wdata[i*D +: D] = data;
  endtask

  task automatic rand_bundle();
    for (int i = 0; i < L; i++)
      set_lane(i, 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)), $urandom);
    mem_hilo_we = 1'($urandom);
    mem_hilo    = {$urandom, $urandom};
  endtask

  // Monitor: every cycle the DUT presents a registered bundle; compare it with the queued expectation.
  initial begin
    exp_t e;
    int er, eb;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
`ifdef PIPE_WB_PERF_EN
        er = e.retired; eb = e.bubbles;
`else
        er = 0; eb = 0;
`endif
        checks++;
        if (wb_valid !== e.valid || wb_we !== e.we || wb_waddr !== e.waddr || wb_wdata !== e.wdata ||
            wb_hilo_we !== e.hilo_we || wb_hilo !== e.hilo) begin
          failures++;
          $display("FAIL wb_bundle t=%0t got v=%b we=%b a=%h d=%h hwe=%b h=%h expected v=%b we=%b a=%h d=%h hwe=%b h=%h",
                   $time, wb_valid, wb_we, wb_waddr, wb_wdata, wb_hilo_we, wb_hilo,
                   e.valid, e.we, e.waddr, e.wdata, e.hilo_we, e.hilo);
        end
        checks++;
        if (int'(perf_retired) != er || int'(perf_bubbles) != eb) begin
          failures++;
          $display("FAIL perf t=%0t got retired=%0d bubbles=%0d expected retired=%0d bubbles=%0d",
                   $time, perf_retired, perf_bubbles, er, eb);
        end
      end
    end
  end

  initial begin
    m = cleared(m);
    m.retired = 0;
    m.bubbles = 0;
    @(negedge clk);
    // Reset with busy inputs, then a two-lane load.
    rst = 1'b1; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
    mem_valid = '1; mem_we = '1; mem_waddr = {5'd9, 5'd10}; mem_wdata = {32'hDEAD, 32'hBEEF};
    mem_hilo_we = 1'b1; mem_hilo = {32'h5, 32'h6};
    step(); step();
    rst = 1'b0; mem_hilo_we = 1'b0; mem_hilo = '0;
    set_lane(0, 1'b1, 1'b1, 3, 32'h11); set_lane(1, 1'b1, 1'b1, 4, 32'h22);
    step();
    // WAW collapse, then $zero suppression on lane 1.
    set_lane(0, 1'b1, 1'b1, 7, 32'hAA); set_lane(1, 1'b1, 1'b1, 7, 32'hBB);
    step();
    set_lane(0, 1'b1, 1'b1, 5, 32'h55); set_lane(1, 1'b1, 1'b1, 0, 32'h66);
    step();
    // Three bubbles.
    stall_mem = 1'b1; stall_wb = 1'b0;
    step(); step(); step();
    // Load, hold four cycles, flush during hold, keep holding zeros.
    stall_mem = 1'b0;
    set_lane(0, 1'b1, 1'b1, 3, 32'h11); set_lane(1, 1'b1, 1'b1, 4, 32'h22);
    step();
    stall_mem = 1'b1; stall_wb = 1'b1;
    step(); step(); step(); step();
    flush = 1'b1; step();
    flush = 1'b0; step(); step();
    // HI/LO gating on any valid lane.
    stall_mem = 1'b0; stall_wb = 1'b0;
    mem_hilo_we = 1'b1; mem_hilo = {32'h1, 32'h2};
    mem_valid = 2'b00; step();
    mem_valid = 2'b01; step();
    // Randomized traffic; resets only in the first part so counters can climb.
    for (int c = 0; c < 3000; c++) begin
      rand_bundle();
      stall_mem = ($urandom_range(0, 99) < 30);
      stall_wb  = ($urandom_range(0, 3) == 0) ? 1'b1 : (stall_mem && $urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = (c < 800) && ($urandom_range(0, 99) == 0);
      step();
    end
    // Drive both counters into saturation.
    rst = 1'b0; flush = 1'b0; stall_wb = 1'b0; stall_mem = 1'b0; mem_valid = 2'b11;
    for (int c = 0; c < 140; c++) step();
    stall_mem = 1'b1;
    for (int c = 0; c < 270; c++) step();
    stall_mem = 1'b0;
    for (int c = 0; c < 4; c++) step();
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_wb_latch.md
# pipe_wb_latch

Parametrised MEM→WB pipeline latch for the multi-issue core. It sits between the memory stage and register-file/HI-LO writeback. Per cycle it carries `LANES` register write requests, one HI/LO write request and per-lane valid bits. Relative to a single-lane latch, it adds:
- flush
- same-bundle write-after-write collapsing
- `$zero` write suppression
- optional retire/bubble performance counters

## Interface
Parameters:
- `LANES`, 2, number of issue lanes (1..4)
- `DATA_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 5, register address width
- `CNT_WIDTH`, 32, performance counter width

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous active-high reset
- `mem_valid`  in  LANES  lane carries a real instruction
- `mem_we`  in  LANES  lane register write enable
- `mem_waddr`  in  LANES*ADDR_WIDTH  lane write address; lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `mem_wdata`  in  LANES*DATA_WIDTH  lane write data, packed the same way
- `mem_hilo_we`  in  1  HI/LO write enable
- `mem_hilo`  in  2*DATA_WIDTH  {HI, LO} data
- `stall_mem`  in  1  MEM stage stalled
- `stall_wb`  in  1  WB stage stalled
- `flush`  in  1  discard bundle (exception/eret)
- `wb_valid`, `wb_we`, `wb_waddr`, `wb_wdata`, `wb_hilo_we`, `wb_hilo`  out  same widths as the `mem_*` inputs  registered outputs
- `perf_retired`  out  CNT_WIDTH  retired instruction count (see Configuration)
- `perf_bubbles`  out  CNT_WIDTH  inserted bubble count (see Configuration)

## Operation
- Per-edge priority, highest first:
  1. `rst`: clear all outputs and counters.
  2. `flush`: clear all `wb_*` outputs; counters hold.
  3. `stall_mem && !stall_wb`: insert a bubble (clear all `wb_*`); increment `perf_bubbles`.
  4. `!stall_mem`: load the bundle.
  5. Otherwise (`stall_mem && stall_wb`): hold all outputs.
- "Clear" means:
  - all `valid`/`we` bits 0
  - addresses and data 0
  - `wb_hilo_we` 0, `wb_hilo` 0
- Load transforms, applied per lane at capture:
  - `wb_we[i] = mem_we[i] && mem_valid[i] && (waddr[i] != 0)`
  - WAW collapse: if lane j > i also has a surviving write to the same address, `wb_we[i] = 0`. The youngest lane wins.
  - `wb_waddr`/`wb_wdata` copied unmodified, even when `we` is dropped.
  - `wb_valid` copied unmodified.
  - `wb_hilo_we = mem_hilo_we && |mem_valid`; `wb_hilo` copied.
- `perf_retired` adds popcount(`mem_valid`) on each load cycle.
- Both counters saturate at all-ones and do not wrap.

## Timing
- Latency: exactly 1 cycle from `mem_*` to `wb_*` when `stall_mem` = 0.
- No combinational path from any input to any output.
- Reset value of every output, counters included, is 0.
- Reset and flush take effect at the edge where they are sampled high.
- Reset asserted mid-stall clears outputs regardless of stall state.
- Flush has priority over stall:
  - A flush while `stall_mem && stall_wb` clears the held bundle.
  - After a flush the latch holds zeros until the next load.
- Bubble insertion repeats each cycle `stall_mem && !stall_wb` persists; one `perf_bubbles` increment per cycle.
- `stall_wb && !stall_mem` is treated as load. Upstream stall control never produces this combination; the latch does not check it.

## Configuration
- `PIPE_WB_PERF_EN` defined: both counters implemented as above.
- `PIPE_WB_PERF_EN` undefined:
  - no counter flops are synthesised
  - `perf_retired` and `perf_bubbles` are tied to constant 0
  - all other behaviour is unchanged

## Test plan
1. **Reset.** Assert `rst` for 2 cycles with nonzero inputs → all `wb_*` and `perf_*` = 0. Deassert, load a bundle with lane0 = {v=1, we=1, addr=3, data=0x11}, lane1 = {v=1, we=1, addr=4, data=0x22} → next cycle outputs match the bundle; `perf_retired` = 2.
2. **WAW collapse and `$zero` suppression.**
   - Lanes 0 and 1 both write addr 7 (0xAA, 0xBB) → `wb_we` = 2'b10; `wb_wdata` lane1 = 0xBB.
   - Lane1 writes addr 0 → `wb_we[1]` = 0 and lane0 write kept.
3. **Bubble.** `stall_mem` = 1, `stall_wb` = 0 for 3 cycles → `wb_*` cleared each cycle; `perf_bubbles` rises by 3; `perf_retired` unchanged.
4. **Hold and flush.**
   - Load the bundle, then `stall_mem` = `stall_wb` = 1 for 4 cycles → outputs stable.
   - Pulse `flush` during the hold → outputs 0 next cycle; counters unchanged.
5. **HI/LO.**
   - `mem_hilo_we` = 1, `mem_hilo` = {0x1, 0x2}, `mem_valid` = 0 → `wb_hilo_we` = 0.
   - Same with `mem_valid` = 2'b01 → `wb_hilo_we` = 1, `wb_hilo` = {0x1, 0x2}.
6. **Saturation** (`CNT_WIDTH` = 4, `PIPE_WB_PERF_EN` defined): 10 loads of 2 valid lanes → `perf_retired` = 15 and stays at 15.
   - Same bench with the macro undefined → `perf_*` = 0 throughout.
